// File: rtl/jpeg_pkg.sv
// Shared constants, state encoding and address helpers for the JPEG MCU colour path.
`timescale 1ns/1ps
package jpeg_pkg;

    localparam int BLK_N       = 64;
    localparam int MCU_SAMPLES = 384;
    localparam int MCU_PIXELS  = 256;
    localparam int CB_BASE     = 256;
    localparam int CR_BASE     = 320;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Luma index inside the 4 Y blocks: {block row, block col, row in block, col in block}.
    function automatic logic [7:0] y_addr(input logic [3:0] px, input logic [3:0] py);
        return {py[3], px[3], py[2:0], px[2:0]};
    endfunction

    // Chroma index inside an 8x8 block with 2x2 nearest-neighbour upsampling.
    function automatic logic [5:0] c_addr(input logic [3:0] px, input logic [3:0] py);
        return {py[3:1], px[3:1]};
    endfunction

endpackage

// File: rtl/mcu_buf.sv
// One MCU of sample storage: linear 384-entry write port, three-sample synchronous read port.
`timescale 1ns/1ps
module mcu_buf
    import jpeg_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [8:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [7:0]    y_raddr,
    input  logic [5:0]    c_raddr,
    output logic [DW-1:0] y_rd,
    output logic [DW-1:0] cb_rd,
    output logic [DW-1:0] cr_rd
);

    logic [DW-1:0] y_mem  [256];
    logic [DW-1:0] cb_mem [64];
    logic [DW-1:0] cr_mem [64];

    logic [DW-1:0] y_rd_q, y_rd_d;
    logic [DW-1:0] cb_rd_q, cb_rd_d;
    logic [DW-1:0] cr_rd_q, cr_rd_d;

    always_ff @(posedge clk) begin
        if (we) begin
            if (waddr < 9'(CB_BASE)) begin
                y_mem[waddr[7:0]] <= wdata;
            end else if (waddr < 9'(CR_BASE)) begin
                cb_mem[waddr[5:0]] <= wdata;
            end else begin
                cr_mem[waddr[5:0]] <= wdata;
            end
        end
    end

    // Read register clears when idle so the downstream outputs are zero between pixels.
    always_comb begin
        y_rd_d  = '0;
        cb_rd_d = '0;
        cr_rd_d = '0;
        if (re) begin
            y_rd_d  = y_mem[y_raddr];
            cb_rd_d = cb_mem[c_raddr];
            cr_rd_d = cr_mem[c_raddr];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_rd_q  <= '0;
            cb_rd_q <= '0;
            cr_rd_q <= '0;
        end else begin
            y_rd_q  <= y_rd_d;
            cb_rd_q <= cb_rd_d;
            cr_rd_q <= cr_rd_d;
        end
    end

    assign y_rd  = y_rd_q;
    assign cb_rd = cb_rd_q;
    assign cr_rd = cr_rd_q;

endmodule

// File: rtl/mcu_color_sched.sv
// 4:2:0 MCU scheduler: buffers six IDCT blocks and drains 256 raster-order (y,cb,cr) pixels.
// Define MCU_PINGPONG_EN for two banks with concurrent fill and drain.
`timescale 1ns/1ps
module mcu_color_sched
    import jpeg_pkg::*;
#(
    parameter int DW    = 8,
    parameter int BLK_N = 64,
    parameter int MCU_W = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          blk_vld_i,
    input  logic [DW-1:0] blk_data_i,
    output logic          blk_rdy_o,
    input  logic          pix_rdy_i,
    output logic          pix_vld_o,
    output logic [DW-1:0] y_o,
    output logic [DW-1:0] cb_o,
    output logic [DW-1:0] cr_o,
    output logic [3:0]    pix_x_o,
    output logic [3:0]    pix_y_o,
    output logic          mcu_done_o,
    output logic          busy_o
);

    localparam logic [8:0] WLAST = 9'(6 * BLK_N - 1);
    localparam logic [7:0] PLAST = 8'(MCU_W * MCU_W - 1);

    state_e     state_q, state_d;
    logic [8:0] wcnt_q, wcnt_d;
    logic [7:0] p_q, p_d;
    logic       blk_rdy_q, blk_rdy_d;
    logic       vld_q, vld_d;
    logic       done_q, done_d;
    logic [3:0] px_q, px_d;
    logic [3:0] py_q, py_d;

    logic       wr, issue, last_wr, last_iss;
    logic [7:0] y_ra;
    logic [5:0] c_ra;

    assign wr       = blk_vld_i & blk_rdy_q;
    assign issue    = (state_q == DRAIN) & pix_rdy_i;
    assign last_wr  = wr & (wcnt_q == WLAST);
    assign last_iss = issue & (p_q == PLAST);
    assign y_ra     = y_addr(p_q[3:0], p_q[7:4]);
    assign c_ra     = c_addr(p_q[3:0], p_q[7:4]);

    always_comb begin
        wcnt_d = wcnt_q;
        p_d    = p_q;
        if (wr) begin
            wcnt_d = last_wr ? 9'd0 : wcnt_q + 9'd1;
        end
        if (issue) begin
            p_d = p_q + 8'd1;
        end
        vld_d  = issue;
        done_d = last_iss;
        px_d   = issue ? p_q[3:0] : 4'd0;
        py_d   = issue ? p_q[7:4] : 4'd0;
    end

`ifdef MCU_PINGPONG_EN
    logic [1:0]    full_q, full_d;
    logic          fill_bank_q, fill_bank_d;
    logic          drain_bank_q, drain_bank_d;
    logic [DW-1:0] y0, cb0, cr0, y1, cb1, cr1;

    // The bank released by the last issue is freed before the completed fill bank is marked full.
    always_comb begin
        full_d       = full_q;
        fill_bank_d  = fill_bank_q;
        drain_bank_d = drain_bank_q;
        state_d      = state_q;
        if (last_iss) begin
            full_d[drain_bank_q] = 1'b0;
            drain_bank_d         = ~drain_bank_q;
        end
        if (last_wr) begin
            full_d[fill_bank_q] = 1'b1;
            fill_bank_d         = ~fill_bank_q;
        end
        if ((state_q == FILL) || last_iss) begin
            state_d = full_d[drain_bank_d] ? DRAIN : FILL;
        end
        blk_rdy_d = ~(full_d[0] & full_d[1]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_q       <= 2'b00;
            fill_bank_q  <= 1'b0;
            drain_bank_q <= 1'b0;
        end else begin
            full_q       <= full_d;
            fill_bank_q  <= fill_bank_d;
            drain_bank_q <= drain_bank_d;
        end
    end

    mcu_buf #(.DW(DW)) u_buf0 (
        .clk(clk), .rstn(rstn),
        .we(wr & ~fill_bank_q), .waddr(wcnt_q), .wdata(blk_data_i),
        .re(issue & ~drain_bank_q), .y_raddr(y_ra), .c_raddr(c_ra),
        .y_rd(y0), .cb_rd(cb0), .cr_rd(cr0)
    );

    mcu_buf #(.DW(DW)) u_buf1 (
        .clk(clk), .rstn(rstn),
        .we(wr & fill_bank_q), .waddr(wcnt_q), .wdata(blk_data_i),
        .re(issue & drain_bank_q), .y_raddr(y_ra), .c_raddr(c_ra),
        .y_rd(y1), .cb_rd(cb1), .cr_rd(cr1)
    );

    // Idle bank read registers are zero, so OR-ing selects the active bank.
    assign y_o    = y0 | y1;
    assign cb_o   = cb0 | cb1;
    assign cr_o   = cr0 | cr1;
    assign busy_o = (state_q == DRAIN) | (|full_q) | (wcnt_q != 9'd0);
`else
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (last_wr)  state_d = DRAIN;
            DRAIN:   if (last_iss) state_d = FILL;
            default: state_d = FILL;
        endcase
        blk_rdy_d = (state_d == FILL);
    end

    mcu_buf #(.DW(DW)) u_buf (
        .clk(clk), .rstn(rstn),
        .we(wr), .waddr(wcnt_q), .wdata(blk_data_i),
        .re(issue), .y_raddr(y_ra), .c_raddr(c_ra),
        .y_rd(y_o), .cb_rd(cb_o), .cr_rd(cr_o)
    );

    assign busy_o = (state_q == DRAIN) | (wcnt_q != 9'd0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= FILL;
            wcnt_q    <= '0;
            p_q       <= '0;
            blk_rdy_q <= 1'b0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            p_q       <= p_d;
            blk_rdy_q <= blk_rdy_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
            px_q      <= px_d;
            py_q      <= py_d;
        end
    end

    assign blk_rdy_o  = blk_rdy_q;
    assign pix_vld_o  = vld_q;
    assign mcu_done_o = done_q;
    assign pix_x_o    = px_q;
    assign pix_y_o    = py_q;

endmodule

// File: tb/tb_mcu_color_sched.sv
// Directed bench for mcu_color_sched: reset, ramp MCU, backpressure, input gaps, reset mid-fill.
`timescale 1ns/1ps
module tb_mcu_color_sched;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       blk_vld_i = 1'b0;
    logic [7:0] blk_data_i = 8'd0;
    logic       blk_rdy_o;
    logic       pix_rdy_i = 1'b0;
    logic       pix_vld_o;
    logic [7:0] y_o, cb_o, cr_o;
    logic [3:0] pix_x_o, pix_y_o;
    logic       mcu_done_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcu_color_sched dut (
        .clk(clk), .rstn(rstn),
        .blk_vld_i(blk_vld_i), .blk_data_i(blk_data_i), .blk_rdy_o(blk_rdy_o),
        .pix_rdy_i(pix_rdy_i), .pix_vld_o(pix_vld_o),
        .y_o(y_o), .cb_o(cb_o), .cr_o(cr_o),
        .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
        .mcu_done_o(mcu_done_o), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sample value for stream index s (0..383) of pattern pat.
    function automatic logic [7:0] gen(input int pat, input int s);
        int i;
        if (pat == 0) begin
            if (s < 256) begin
                i = s % 64;
                return 8'(16 * (s / 64) + (i % 16));
            end else if (s < 320) begin
                return 8'(128 + s - 256);
            end
            return 8'(64 + s - 320);
        end
        return 8'((s * 5 + 1) % 256);
    endfunction

    // Stream index holding component comp (0=Y,1=Cb,2=Cr) for pixel (px,py).
    function automatic int src(input int comp, input int px, input int py);
        if (comp == 0) return ((py / 8) * 2 + (px / 8)) * 64 + (py % 8) * 8 + (px % 8);
        if (comp == 1) return 256 + (py / 2) * 8 + (px / 2);
        return 320 + (py / 2) * 8 + (px / 2);
    endfunction

    task automatic send_sample(input logic [7:0] d, input int gaps);
        int guard;
        repeat (gaps) begin
            blk_vld_i = 1'b0;
            @(posedge clk); #1;
        end
        blk_vld_i  = 1'b1;
        blk_data_i = d;
        guard = 0;
        while (!blk_rdy_o && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 2000) begin
            errors++;
            $display("FAIL send_timeout observed=blk_rdy_o low expected=high");
        end
        @(posedge clk); #1;
        blk_vld_i = 1'b0;
    endtask

    task automatic send_mcu(input int pat, input bit gappy);
        for (int s = 0; s < 384; s++) begin
            send_sample(gen(pat, s), gappy ? int'($urandom_range(0, 1)) : 0);
        end
    endtask

    // Called in the cycle right after the last input sample was accepted.
    task automatic drain_check(input int pat, input bit toggle, input string tag);
        int beat, cyc, px, py;
        logic r;
        beat = 0;
        cyc  = 0;
        chk({tag, "_vld_t1"}, pix_vld_o, 0);
        chk({tag, "_rdy_t1"}, blk_rdy_o, 0);
        while (beat < 256 && cyc < 1200) begin
            r = toggle ? (cyc % 2 == 0) : 1'b1;
            pix_rdy_i = r;
            @(posedge clk); #1;
            cyc++;
            chk({tag, "_vld"}, pix_vld_o, r);
            if (pix_vld_o) begin
                px = beat % 16;
                py = beat / 16;
                chk({tag, "_x"}, pix_x_o, px);
                chk({tag, "_y"}, pix_y_o, py);
                chk({tag, "_ydat"}, y_o, gen(pat, src(0, px, py)));
                chk({tag, "_cb"}, cb_o, gen(pat, src(1, px, py)));
                chk({tag, "_cr"}, cr_o, gen(pat, src(2, px, py)));
                chk({tag, "_done"}, mcu_done_o, beat == 255);
                chk({tag, "_blkrdy"}, blk_rdy_o, beat == 255);
                if (pat == 0 && beat == 41) begin
                    chk({tag, "_p9_2_y"}, y_o, 17);
                    chk({tag, "_p9_2_cb"}, cb_o, 140);
                    chk({tag, "_p9_2_cr"}, cr_o, 76);
                end
                beat++;
            end else begin
                chk({tag, "_idle_y"}, y_o, 0);
                chk({tag, "_idle_done"}, mcu_done_o, 0);
                chk({tag, "_busy"}, busy_o, 1);
                chk({tag, "_blkrdy_idle"}, blk_rdy_o, 0);
            end
        end
        chk({tag, "_beats"}, beat, 256);
        pix_rdy_i = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_vld_after"}, pix_vld_o, 0);
        chk({tag, "_done_after"}, mcu_done_o, 0);
        chk({tag, "_rdy_after"}, blk_rdy_o, 1);
        chk({tag, "_busy_after"}, busy_o, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vld"}, pix_vld_o, 0);
        chk({tag, "_y"}, y_o, 0);
        chk({tag, "_cb"}, cb_o, 0);
        chk({tag, "_cr"}, cr_o, 0);
        chk({tag, "_x"}, pix_x_o, 0);
        chk({tag, "_py"}, pix_y_o, 0);
        chk({tag, "_done"}, mcu_done_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_rdy"}, blk_rdy_o, 0);
    endtask

    task automatic idle_no_vld(input int n, input string tag);
        int seen;
        seen = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (pix_vld_o) seen++;
        end
        chk({tag, "_vld_count"}, seen, 0);
    endtask

    initial begin
        // Reset and idle
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        #2 rstn = 1'b1;
        chk("rdy_at_release", blk_rdy_o, 0);
        @(posedge clk); #1;
        chk("rdy_first_cycle", blk_rdy_o, 1);
        pix_rdy_i = 1'b1;
        idle_no_vld(100, "idle");
        chk("idle_busy", busy_o, 0);

`ifdef MCU_PINGPONG_EN
        begin
            int pp_beats, pp_done, pp_sent, pp_cyc, px, py, pat;
            bit rdy_drop;
            pp_beats = 0; pp_done = 0; pp_sent = 0; pp_cyc = 0; rdy_drop = 1'b0;
            fork
                begin
                    for (int m = 0; m < 3; m++) begin
                        for (int s = 0; s < 384; s++) begin
                            send_sample(gen(m % 2, s), 0);
                            pp_sent++;
                        end
                    end
                end
                begin
                    while (pp_beats < 768 && pp_cyc < 5000) begin
                        @(posedge clk); #1;
                        pp_cyc++;
                        if (pp_sent > 384 && pp_sent < 767 && !blk_rdy_o) rdy_drop = 1'b1;
                        if (pix_vld_o) begin
                            pat = (pp_beats / 256) % 2;
                            px = (pp_beats % 256) % 16;
                            py = (pp_beats % 256) / 16;
                            chk("pp_x", pix_x_o, px);
                            chk("pp_y", pix_y_o, py);
                            chk("pp_ydat", y_o, gen(pat, src(0, px, py)));
                            chk("pp_cb", cb_o, gen(pat, src(1, px, py)));
                            chk("pp_cr", cr_o, gen(pat, src(2, px, py)));
                            if (mcu_done_o) pp_done++;
                            pp_beats++;
                        end
                    end
                end
            join
            chk("pp_beats", pp_beats, 768);
            chk("pp_done", pp_done, 3);
            chk("pp_rdy_mcu2", rdy_drop, 0);
        end
`else
        // Ramp MCU, full-rate drain
        send_mcu(0, 1'b0);
        drain_check(0, 1'b0, "ramp");

        // Backpressure with pix_rdy_i toggling 1010...
        send_mcu(1, 1'b0);
        drain_check(1, 1'b1, "bp");

        // Random input gaps
        send_mcu(0, 1'b1);
        drain_check(0, 1'b0, "gaps");

        // Reset mid-fill discards the partial MCU
        for (int s = 0; s < 200; s++) send_sample(gen(1, s), 0);
        chk("midfill_busy", busy_o, 1);
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        chk("midreset_rdy", blk_rdy_o, 1);
        idle_no_vld(20, "after_midreset");
        send_mcu(0, 1'b0);
        drain_check(0, 1'b0, "post_reset");
        idle_no_vld(20, "tail");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcu_color_sched.md
Name: mcu_color_sched

Overview:
- Sequencer between the IDCT output stage and the YCbCr-to-RGB converter for 4:2:0 baseline JPEG.
- Buffers one MCU of six 8x8 blocks (Y0, Y1, Y2, Y3, Cb, Cr), then drains it to the converter as 256 raster-order (y, cb, cr) triples.
- Upsamples chroma by nearest neighbour and tags each pixel with its MCU-local coordinates.

Parameters:
- DW, 8, sample width of Y/Cb/Cr.
- BLK_N, 64, samples per 8x8 block.
- MCU_W, 16, MCU width and height in pixels.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset: asynchronous, active-low.
- blk_vld_i  in  1  input sample valid.
- blk_data_i  in  DW  input sample, unsigned, level-shifted 0..255.
- blk_rdy_o  out  1  scheduler can accept a sample.
- pix_rdy_i  in  1  converter sink can take a triple.
- pix_vld_o  out  1  triple valid; drives converter vld_i.
- y_o  out  DW  luma to converter.
- cb_o  out  DW  chroma blue to converter.
- cr_o  out  DW  chroma red to converter.
- pix_x_o  out  4  MCU-local column of the emitted pixel.
- pix_y_o  out  4  MCU-local row of the emitted pixel.
- mcu_done_o  out  1  one-cycle pulse with the last pixel of an MCU.
- busy_o  out  1  high in DRAIN, or whenever any bank holds data.

Behaviour:
- Reset values: pix_vld_o, y_o, cb_o, cr_o, pix_x_o, pix_y_o, mcu_done_o, busy_o and blk_rdy_o all 0. State FILL; all counters 0.
- blk_rdy_o rises the first cycle after reset release.
- Input ordering: blocks arrive Y0 (TL), Y1 (TR), Y2 (BL), Y3 (BR), Cb, Cr. Samples within a block are raster order; zigzag is already undone.
- Input transfer occurs on blk_vld_i & blk_rdy_o. A 9-bit write counter runs 0..383 and is the buffer address; samples with blk_vld_i low are ignored.
- FILL state: blk_rdy_o = 1.
  - On the transfer at write count 383, the next state is DRAIN and blk_rdy_o drops the following cycle.
- DRAIN state: blk_rdy_o = 0; an 8-bit pixel counter p = {py[3:0], px[3:0]} is active.
  - Issue occurs in any DRAIN cycle with pix_rdy_i = 1; p then increments. If pix_rdy_i = 0, p holds and pix_vld_o is 0 next cycle.
- Address generation for pixel (px, py):
  - Y address = ((py>>3)*2 + (px>>3))*64 + (py&7)*8 + (px&7).
  - Cb address = 256 + (py>>1)*8 + (px>>1).
  - Cr address = 320 + (py>>1)*8 + (px>>1).
- Buffer read is synchronous with 1-cycle latency. An issue in cycle c produces pix_vld_o = 1 with data and coordinates at c+1.
  - All pixel outputs are registered and return to 0 in cycles with no valid pixel.
- Latency: last input sample accepted at cycle t gives the first pix_vld_o at t+2, given pix_rdy_i = 1.
- Issuing p = 255 returns the state to FILL the next cycle. mcu_done_o = 1 in the same cycle as that pixel's pix_vld_o, and blk_rdy_o = 1 from the same cycle.
- Wrap: p wraps 255 -> 0 and the write counter wraps 383 -> 0; both are cleared on the state change.
- Reset mid-MCU discards the partial MCU; no pix_vld_o follows reset release until a full 384 samples have been accepted.
- Sink contract: the converter output is consumed unconditionally one cycle after pix_vld_o. pix_rdy_i therefore reflects sink space two cycles ahead.

Optional Feature:
- Macro MCU_PINGPONG_EN.
- Defined:
  - Two 384-sample banks.
  - FILL and DRAIN run concurrently on opposite banks; the fill bank toggles when its write counter wraps.
  - blk_rdy_o = 0 only while both banks are full.
  - Drain starts on the oldest full bank the cycle after it completes, or immediately after the previous drain ends.
  - Simultaneous last-write and last-issue: the bank being released is freed first, so blk_rdy_o stays 1.
- Undefined: single bank; FILL and DRAIN are strictly alternating as described above.

Decomposition:
- Package jpeg_pkg holds: BLK_N, MCU_SAMPLES = 384, MCU_PIXELS = 256, CB_BASE = 256, CR_BASE = 320, and state encoding enum {FILL, DRAIN}.
- One sub-module, mcu_buf:
  - 384 x DW (x2 banks when MCU_PINGPONG_EN is defined).
  - One write port and one synchronous read port, which returns three samples (Y, Cb, Cr) per cycle.
  - Implemented as three arrays: Y (256), Cb (64), Cr (64).

Test Plan:
- Reset then idle: after rstn rises, all outputs are 0 and blk_rdy_o = 1 on the next cycle; no pix_vld_o for 100 cycles.
- Ramp MCU: Y block k sample i = 16*k + (i&15), Cb = 128 + i, Cr = 64 + i, pix_rdy_i = 1.
  - 256 contiguous pix_vld_o beats starting at t+2.
  - Pixel (9,2) gives y = 16 + 25 = 41? No: it comes from block Y1 index 17, so y = 16*1 + 1 = 17; cb = 128 + 12 = 140; cr = 76.
  - mcu_done_o on beat 256.
- Backpressure: pix_rdy_i toggled 1010...
  - 256 beats still emitted; pix_x_o/pix_y_o sequence is gap-free 0..255 in raster order.
  - No duplicates; pix_vld_o = 0 one cycle after each pix_rdy_i = 0.
- Input gaps: blk_vld_i random 50%; buffer contents identical; blk_rdy_o = 0 for the entire DRAIN.
- Reset mid-fill: assert rstn low after 200 samples, then send one full MCU; exactly 256 output beats, matching the new MCU.
- MCU_PINGPONG_EN: send 3 back-to-back MCUs with pix_rdy_i = 1.
  - blk_rdy_o never drops during MCU 2.
  - 768 beats total; 3 mcu_done_o pulses.
